// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank driver: controller states and excitation styles.
package jk_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FAULT  = 2'd1,
        ST_RESYNC = 2'd2
    } jk_state_e;

    localparam int unsigned EXC_SR  = 0;
    localparam int unsigned EXC_TOG = 1;

endpackage : jk_pkg

// File: rtl/jk_excite.sv
// Per-bit J/K excitation that moves a JK bank from value e_i to value n_i in one edge.
module jk_excite
    import jk_pkg::*;
#(
    parameter int unsigned W      = 4,
    parameter int unsigned TOGGLE = EXC_SR
) (
    input  logic [W-1:0] e_i,
    input  logic [W-1:0] n_i,
    output logic [W-1:0] j_o,
    output logic [W-1:0] k_o
);

    generate
        if (TOGGLE == EXC_TOG) begin : g_toggle
            // Toggle exactly the bits that differ.
            assign j_o = n_i ^ e_i;
            assign k_o = n_i ^ e_i;
        end else begin : g_set_reset
            // Set rising bits, reset falling bits; never J=K=1.
            assign j_o = n_i & ~e_i;
            assign k_o = ~n_i & e_i;
        end
    endgenerate

endmodule : jk_excite

// File: rtl/jk_counter_driver.sv
// Count/load controller for a JK flip-flop bank: tracks the expected bank value,
// detects Q-feedback mismatches, freezes on fault and resynchronises from Q on clear.
module jk_counter_driver
    import jk_pkg::*;
#(
    parameter int unsigned W      = 4,
    parameter int unsigned TOGGLE = EXC_SR
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         up_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    input  logic         clr_i,
    input  logic [W-1:0] qfb_i,
    output logic [W-1:0] j_c_o,
    output logic [W-1:0] k_c_o,
    output logic [W-1:0] exp_o,
    output logic         wrap_o,
    output logic         err_o
);

    jk_state_e    state_q, state_d;
    logic [W-1:0] exp_q, exp_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;
    logic [W-1:0] next_c;
    logic         mismatch_c;

    assign mismatch_c = (qfb_i != exp_q);

    // Next-state, next-value and flag logic; next_c == exp_q keeps J=K=0.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        next_c  = exp_q;
        case (state_q)
            ST_RUN: begin
                if (mismatch_c) begin
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                end else begin
                    if (load_i) begin
                        next_c = d_i;
                    end else if (en_i) begin
                        next_c = up_i ? (exp_q + W'(1)) : (exp_q - W'(1));
                    end
                    exp_d  = next_c;
                    wrap_d = en_i & ~load_i & (up_i ? (exp_q == {W{1'b1}})
                                                    : (exp_q == {W{1'b0}}));
                end
            end
            ST_FAULT: begin
                if (clr_i) begin
                    state_d = ST_RESYNC;
                end
            end
            ST_RESYNC: begin
                exp_d   = qfb_i;
                err_d   = 1'b0;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            exp_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    jk_excite #(
        .W      (W),
        .TOGGLE (TOGGLE)
    ) u_excite (
        .e_i (exp_q),
        .n_i (next_c),
        .j_o (j_c_o),
        .k_o (k_c_o)
    );

    assign exp_o  = exp_q;
    assign wrap_o = wrap_q;
    assign err_o  = err_q;

endmodule : jk_counter_driver

// File: tb/tb_jk_counter_driver.sv
// Bench: two drivers (set/reset and toggle style), each feeding its own behavioural JK bank,
// checked every cycle against an arithmetic model of the expected value, flags and excitation.
module tb_jk_counter_driver;

    logic       clk;
    logic       rst_n, en, up, load, clr;
    logic [3:0] d, stuck;
    logic [3:0] bq0, bq1, qfb0, qfb1;
    logic [3:0] j0, k0, j1, k1, e0, e1;
    logic       w0, w1, r0, r1;

    int nvec = 0;
    int nerr = 0;

    // model state: mode 0 = running, 1 = faulted, 2 = resyncing
    int m_e, m_mode, n_e, n_mode;
    bit m_wrap, m_err, n_wrap, n_err;
    logic [3:0] lj0, lk0, lj1, lk1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign qfb0 = bq0 | stuck;
    assign qfb1 = bq1 | stuck;

    // behavioural JK banks: Q+ = J&~Q | ~K&Q
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bq0 <= 4'h0;
            bq1 <= 4'h0;
        end else begin
            bq0 <= (j0 & ~bq0) | (~k0 & bq0);
            bq1 <= (j1 & ~bq1) | (~k1 & bq1);
        end
    end

    jk_counter_driver #(.W(4), .TOGGLE(0)) u_sr (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .load_i(load), .d_i(d),
        .clr_i(clr), .qfb_i(qfb0), .j_c_o(j0), .k_c_o(k0), .exp_o(e0), .wrap_o(w0), .err_o(r0));

    jk_counter_driver #(.W(4), .TOGGLE(1)) u_tog (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .load_i(load), .d_i(d),
        .clr_i(clr), .qfb_i(qfb1), .j_c_o(j1), .k_c_o(k1), .exp_o(e1), .wrap_o(w1), .err_o(r1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_e = 0; m_mode = 0; m_wrap = 0; m_err = 0;
    endtask

    // Drive one cycle, check everything before the edge, then advance the model.
    task automatic cycle(input bit en_v, input bit up_v, input bit ld_v, input logic [3:0] d_v,
                         input bit clr_v, input logic [3:0] sm);
        int  nv;
        bit  act;
        logic [3:0] xj, xk, xt;
        en = en_v; up = up_v; load = ld_v; d = d_v; clr = clr_v; stuck = sm;
        @(negedge clk);
        act = (m_mode == 0) && (int'(qfb0) == m_e);
        nv  = m_e;
        if (act) begin
            if (ld_v)      nv = int'(d_v);
            else if (en_v) nv = up_v ? (m_e + 1) % 16 : (m_e + 15) % 16;
        end
        xj = 4'(nv & ~m_e);
        xk = 4'(~nv & m_e);
        xt = 4'(nv ^ m_e);
        chk("exp_sr",  32'(e0), 32'(m_e));
        chk("exp_tog", 32'(e1), 32'(m_e));
        chk("wrap_sr", 32'(w0), 32'(m_wrap));
        chk("wrap_tog", 32'(w1), 32'(m_wrap));
        chk("err_sr",  32'(r0), 32'(m_err));
        chk("err_tog", 32'(r1), 32'(m_err));
        chk("j_sr",    32'(j0), 32'(xj));
        chk("k_sr",    32'(k0), 32'(xk));
        chk("jk_sr_both", 32'(j0 & k0), 32'(0));
        chk("j_tog",   32'(j1), 32'(xt));
        chk("k_tog",   32'(k1), 32'(xt));
        lj0 = j0; lk0 = k0; lj1 = j1; lk1 = k1;
        n_e = m_e; n_mode = m_mode; n_wrap = 0; n_err = m_err;
        case (m_mode)
            0: begin
                if (!act) begin
                    n_mode = 1; n_err = 1;
                end else begin
                    n_e    = nv;
                    n_wrap = en_v && !ld_v && ((up_v && m_e == 15) || (!up_v && m_e == 0));
                end
            end
            1: n_mode = clr_v ? 2 : 1;
            default: begin
                n_e = int'(qfb0); n_err = 0; n_mode = 0;
            end
        endcase
        @(posedge clk);
        #1;
        m_e = n_e; m_mode = n_mode; m_wrap = n_wrap; m_err = n_err;
    endtask

    initial begin
        logic [3:0] sm;
        rst_n = 1'b0; en = 0; up = 0; load = 0; d = 0; clr = 0; stuck = 0;
        model_reset();
        #3;
        chk("rst_exp", 32'(e0), 32'(0));
        chk("rst_err", 32'(r0), 32'(0));
        chk("rst_wrap", 32'(w0), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // count up through the wrap
        for (int i = 0; i < 16; i++) begin
            cycle(1, 1, 0, 4'h0, 0, 4'h0);
            chk("t1_exp", 32'(e0), 32'((i + 1) % 16));
            chk("t1_wrap", 32'(w0), 32'(i == 15));
            chk("t1_qfb", 32'(qfb0), 32'((i + 1) % 16));
        end
        chk("t1_err", 32'(r0), 32'(0));

        // count down from 3 through the underflow
        cycle(0, 0, 1, 4'h3, 0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 4'h0, 0, 4'h0);
            chk("t2_exp", 32'(e0), 32'((18 - i) % 16));
            chk("t2_wrap", 32'(w0), 32'(i == 3));
        end

        // load beats count
        cycle(0, 0, 1, 4'h0, 0, 4'h0);
        cycle(1, 1, 1, 4'hA, 0, 4'h0);
        chk("t3_exp", 32'(e0), 32'hA);
        chk("t3_j", 32'(lj0), 32'b1010);
        chk("t3_k", 32'(lk0), 32'h0);

        // stuck-at-1 fault, hold, clear, resync, resume
        cycle(0, 0, 1, 4'h4, 0, 4'h0);
        cycle(1, 1, 0, 4'h0, 0, 4'b0001);
        chk("t4_j_forced", 32'(lj0), 32'h0);
        chk("t4_k_forced", 32'(lk0), 32'h0);
        chk("t4_err", 32'(r0), 32'(1));
        chk("t4_exp_held", 32'(e0), 32'h4);
        cycle(1, 1, 0, 4'h0, 0, 4'h0);
        chk("t4_fault_hold", 32'(e0), 32'h4);
        cycle(1, 1, 0, 4'h0, 1, 4'h0);
        chk("t4_clr_err", 32'(r0), 32'(1));
        cycle(1, 1, 1, 4'hF, 0, 4'h0);
        chk("t4_resync_exp", 32'(e0), 32'h4);
        chk("t4_resync_err", 32'(r0), 32'(0));
        cycle(1, 1, 0, 4'h0, 0, 4'h0);
        chk("t4_resume", 32'(e0), 32'h5);

        // toggle style from 7 to 8
        cycle(0, 0, 1, 4'h7, 0, 4'h0);
        cycle(1, 1, 0, 4'h0, 0, 4'h0);
        chk("t5_j_tog", 32'(lj1), 32'hF);
        chk("t5_k_tog", 32'(lk1), 32'hF);
        chk("t5_j_sr", 32'(lj0), 32'h8);
        chk("t5_k_sr", 32'(lk0), 32'h7);
        chk("t5_exp", 32'(e1), 32'h8);

        // async reset while faulted
        cycle(0, 0, 1, 4'h9, 0, 4'h0);
        cycle(0, 0, 0, 4'h0, 0, 4'b0010);
        chk("t6_err", 32'(r0), 32'(1));
        chk("t6_exp", 32'(e0), 32'h9);
        stuck = 4'h0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_exp", 32'(e0), 32'h0);
        chk("t6_rst_err", 32'(r0), 32'(0));
        chk("t6_rst_wrap", 32'(w0), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1, 1, 0, 4'h0, 0, 4'h0);
        chk("t6_run_after", 32'(e0), 32'h1);

        // randomized commands with occasional single-cycle stuck bits
        for (int i = 0; i < 600; i++) begin
            sm = 4'h0;
            if (m_mode == 0 && !m_wrap && $urandom_range(0, 24) == 0)
                sm = 4'(1 << $urandom_range(0, 3));
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) == 0), sm);
        end
        cycle(0, 0, 0, 4'h0, 0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_jk_counter_driver
